imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Registered RV32I/RV64I immediate generator for the ID stage. Decodes all base formats
//  (I, S, B, U, J, shift-imm), sign-extends the immediate to XLEN and reports the format.
//  It sits between IF/ID and the ID/EX register, using a valid/ready handshake with a skid buffer.
//  Successor to the single-cycle combinational extender, which handled only I/S/B at 32 bits.
// PARAMETERS
//  XLEN     32  output width; legal values 32 or 64 (64 also widens shamt to inst[25:20])
//  SKID_EN  1   1: 2-entry (main+skid) buffer, registered ready_o; 0: main register only
// PORTS
//  clk_i      in   1     clock; all state updates on the rising edge
//  rst_i      in   1     synchronous, active-high reset
//  flush_i    in   1     drop all buffered entries (branch mispredict / exception)
//  inst_i     in   32    instruction word
//  valid_i    in   1     inst_i valid
//  ready_o    out  1     block accepts inst_i this cycle
//  imm_o      out  XLEN  extended immediate
//  fmt_o      out  3     0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH (shift-imm), 7 ILL
//  illegal_o  out  1     opcode is not in the decode table (fmt_o==7)
//  valid_o    out  1     imm_o/fmt_o/illegal_o valid
//  ready_i    in   1     downstream accepts the output this cycle
// BEHAVIOUR
//  Decode (opcode = inst[6:0]); sign bit = inst[31], replicated up to XLEN-1:
//   0010011 OP-IMM: funct3 001/101 -> SH, imm = zero-ext shamt (inst[24:20], XLEN=64: inst[25:20]);
//                   otherwise I, imm = sext(inst[31:20])
//   0000011 LOAD, 1100111 JALR -> I;  0100011 STORE -> S, sext({inst[31:25],inst[11:7]})
//   1100011 BRANCH -> B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//   0110111 LUI, 0010111 AUIPC -> U, sext({inst[31:12],12'b0})
//   1101111 JAL -> J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//   0110011 OP -> R, imm 0;  any other opcode -> ILL, imm 0, illegal_o=1
//  Timing: latency 1 cycle; inst_i accepted at edge N is presented on imm_o after edge N.
//  Handshake: input transfer = valid_i & ready_o; output transfer = valid_o & ready_i.
//   While valid_o & ~ready_i, imm_o/fmt_o/illegal_o/valid_o hold stable.
//   SKID_EN=1: ready_o = ~skid_valid (registered). An accept while main is full and stalled
//    goes to skid. On output transfer, skid moves to main. Order is strictly FIFO.
//    Accept and drain in the same cycle gives full throughput of 1/cycle.
//   SKID_EN=0: ready_o = ~valid_o | ready_i (combinational).
//  States (SKID_EN=1): EMPTY (valid_o=0) -> ONE on accept; ONE -> EMPTY on drain without accept;
//   ONE -> TWO on accept without drain; TWO -> ONE on drain (no accept possible);
//   ONE stays ONE on simultaneous accept+drain.
//  Flush: at the next edge, valid_o=0, skid empty, ready_o=1; an input offered in the flush cycle is dropped.
//  Reset (rst_i=1 at edge): valid_o=0, imm_o=0, fmt_o=0, illegal_o=0, skid empty.
//   ready_o=0 while rst_i is high, 1 in the first cycle after. Reset mid-stall discards both entries.
//   Reset has priority over flush.
//  Output data registers update only on load (no toggling when idle).
// TESTING
//  T1 XLEN=32: 0xFFF00093 (addi -1) -> next cycle imm_o=0xFFFFFFFF, fmt_o=1, valid_o=1.
//  T2 0xFE112E23 (sw -4) -> 0xFFFFFFFC fmt 2; 0xFE000CE3 (beq -8) -> 0xFFFFFFF8 fmt 3;
//     0x001000EF (jal +2048) -> 0x00000800 fmt 5.
//  T3 0x123450B7 (lui) -> 0x12345000 fmt 4; 0x4030D093 (srai 3) -> 0x00000003 fmt 6.
//     XLEN=64: 0x800000B7 -> 0xFFFFFFFF80000000.
//  T4 0x0000007F -> illegal_o=1, fmt_o=7, imm_o=0; 0x002081B3 (add) -> fmt 0, imm 0, illegal_o=0.
//  T5 ready_i=0, back-to-back A,B,C: A in main, B in skid, ready_o=0, C held; imm_o stable at A.
//     ready_i=1 -> A, B, C emerge in order, no loss or duplication.
//  T6 Flush with two entries held -> valid_o=0, ready_o=1 next cycle. rst_i mid-stream -> all
//     outputs 0 next cycle; ready_o=0 during reset, 1 in the first cycle after.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator for the ID stage, with a valid/ready handshake
// and an optional one-entry skid buffer behind the main output register.
module imm_gen_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [31:0]     inst_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o,
    output logic            valid_o,
    input  logic            ready_i
);

    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtB   = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtJ   = 3'd5;
    localparam logic [2:0] FmtSh  = 3'd6;
    localparam logic [2:0] FmtIll = 3'd7;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state, state_next;

    logic            skid_valid;
    logic            accept, drain, load_main, load_skid;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic signed [31:0] imm32;
    logic [5:0]      shamt;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;

    // Immediate decode: every format is sign-extended to 32 bits first, then to XLEN.
    always_comb begin
        imm32   = '0;
        dec_fmt = FmtIll;
        dec_imm = '0;
        shamt   = {(XLEN == 64) & inst_i[25], inst_i[24:20]};
        case (inst_i[6:0])
            7'b0010011: begin
                if (inst_i[13:12] == 2'b01) begin
                    dec_fmt = FmtSh;
                end else begin
                    dec_fmt = FmtI;
                    imm32   = 32'($signed(inst_i[31:20]));
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_fmt = FmtI;
                imm32   = 32'($signed(inst_i[31:20]));
            end
            7'b0100011: begin
                dec_fmt = FmtS;
                imm32   = 32'($signed({inst_i[31:25], inst_i[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FmtB;
                imm32   = 32'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FmtU;
                imm32   = {inst_i[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FmtJ;
                imm32   = 32'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                                       1'b0}));
            end
            7'b0110011: dec_fmt = FmtR;
            default:    dec_fmt = FmtIll;
        endcase
        if (dec_fmt == FmtSh) begin
            dec_imm = XLEN'(shamt);
        end else begin
            dec_imm = XLEN'(imm32);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= StEmpty;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = StEmpty;
        end else begin
            unique case (state)
                StEmpty: if (accept) state_next = StOne;
                StOne: begin
                    if (accept && !drain && SKID_EN) begin
                        state_next = StTwo;
                    end else if (!accept && drain) begin
                        state_next = StEmpty;
                    end
                end
                StTwo:   if (drain) state_next = StOne;
                default: state_next = StEmpty;
            endcase
        end
    end

    // Ready is held low for the whole reset cycle so nothing is offered into a clearing pipe.
    always_comb begin
        valid_o    = (state != StEmpty);
        skid_valid = (state == StTwo);
        if (SKID_EN) begin
            ready_o = !rst_i && !skid_valid;
        end else begin
            ready_o = !rst_i && (!valid_o || ready_i);
        end
    end

    assign accept    = valid_i && ready_o && !flush_i;
    assign drain     = valid_o && ready_i;
    assign load_main = !flush_i && ((skid_valid && drain) || (accept && (!valid_o || drain)));
    assign load_skid = !flush_i && accept && valid_o && !drain && SKID_EN;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imm_o     <= '0;
            fmt_o     <= FmtR;
            illegal_o <= 1'b0;
            skid_imm  <= '0;
            skid_fmt  <= FmtR;
        end else begin
            if (load_main) begin
                if (skid_valid) begin
                    imm_o     <= skid_imm;
                    fmt_o     <= skid_fmt;
                    illegal_o <= (skid_fmt == FmtIll);
                end else begin
                    imm_o     <= dec_imm;
                    fmt_o     <= dec_fmt;
                    illegal_o <= (dec_fmt == FmtIll);
                end
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
            end
        end
    end

endmodule
